// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample store and its controller.
`timescale 1ns/1ps
package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int SRAM_ADDR_W = 20;

  // State codes as seen by the top controller on state_o
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_REC  = 2'd1;
  localparam logic [1:0] STATE_PLAY = 2'd2;

  typedef enum logic [1:0] {
    BUF_IDLE = STATE_IDLE,
    BUF_REC  = STATE_REC,
    BUF_PLAY = STATE_PLAY
  } buf_state_e;

  typedef enum logic [2:0] {
    PORT_IDLE,
    PORT_W1,
    PORT_W2,
    PORT_R1,
    PORT_R2
  } port_phase_e;
endpackage

// File: rtl/audio_sram_buffer_sram_port.sv
// Two-cycle asynchronous-SRAM access sequencer; all SRAM pins come straight from registers.
`timescale 1ns/1ps
module sram_port
  import audio_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [SAMPLE_W-1:0] wdata,
  output logic                busy,
  output logic                ack,
  output logic [SAMPLE_W-1:0] rdata,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SAMPLE_W-1:0] sram_dq_o,
  input  logic [SAMPLE_W-1:0] sram_dq_i,
  output logic                sram_dq_oe,
  output logic                sram_oe_n,
  output logic                sram_we_n
);
  port_phase_e phase_reg;

  assign busy = (phase_reg != PORT_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg  <= PORT_IDLE;
      ack        <= 1'b0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      case (phase_reg)
        PORT_IDLE: begin
          if (req) begin
            sram_addr <= addr;
            if (we) begin
              sram_dq_o  <= wdata;
              sram_dq_oe <= 1'b1;
              sram_we_n  <= 1'b0;
              phase_reg  <= PORT_W1;
            end else begin
              sram_oe_n <= 1'b0;
              phase_reg <= PORT_R1;
            end
          end
        end
        // DQ stays driven through W2 so data holds past the rising edge of we_n
        PORT_W1: begin
          sram_we_n <= 1'b1;
          ack       <= 1'b1;
          phase_reg <= PORT_W2;
        end
        PORT_W2: begin
          ack        <= 1'b0;
          sram_dq_oe <= 1'b0;
          phase_reg  <= PORT_IDLE;
        end
        PORT_R1: begin
          sram_oe_n <= 1'b1;
          rdata     <= sram_dq_i;
          ack       <= 1'b1;
          phase_reg <= PORT_R2;
        end
        PORT_R2: begin
          ack       <= 1'b0;
          phase_reg <= PORT_IDLE;
        end
        default: phase_reg <= PORT_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/audio_sram_buffer.sv
// Record/playback sample store: mode FSM, shared pointer and recording length;
// SRAM pin timing is delegated to sram_port.
`timescale 1ns/1ps
module audio_sram_buffer
  import audio_pkg::*;
#(
  parameter int          ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned MAX_LEN = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_rec,
  input  logic                start_play,
  input  logic                stop,
  input  logic [SAMPLE_W-1:0] rec_data,
  input  logic                rec_valid,
  input  logic                play_req,
  output logic [SAMPLE_W-1:0] play_data,
  output logic                play_valid,
  output logic [1:0]          state_o,
  output logic [ADDR_W:0]     length,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                done,
  output logic                overrun,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [SAMPLE_W-1:0] sram_dq_o,
  input  logic [SAMPLE_W-1:0] sram_dq_i,
  output logic                sram_dq_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic                sram_lb_n,
  output logic                sram_ub_n
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  buf_state_e        state_reg;
  logic [ADDR_W:0]   ptr_reg;
  logic [ADDR_W:0]   length_reg;
  logic              stop_pend_reg;
  logic              done_reg;
  logic              overrun_reg;

  logic              port_req;
  logic              port_we;
  logic              port_busy;
  logic              port_ack;
  logic [SAMPLE_W-1:0] port_rdata;
  logic              in_flight;
  logic              stop_any;
  logic [ADDR_W:0]   ptr_next;

  // in_flight: access issued but not in its final cycle (W1/R1)
  always_comb begin
    in_flight = port_busy & ~port_ack;
    stop_any  = stop | stop_pend_reg;
    ptr_next  = ptr_reg + ONE;
    port_we   = (state_reg == BUF_REC);
    port_req  = ~port_busy & ~stop_any &
                (((state_reg == BUF_REC)  & rec_valid) |
                 ((state_reg == BUF_PLAY) & play_req));
  end

  sram_port #(.ADDR_W(ADDR_W)) u_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (port_req),
    .we         (port_we),
    .addr       (ptr_reg[ADDR_W-1:0]),
    .wdata      (rec_data),
    .busy       (port_busy),
    .ack        (port_ack),
    .rdata      (port_rdata),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= BUF_IDLE;
      ptr_reg       <= '0;
      length_reg    <= '0;
      stop_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        BUF_IDLE: begin
          stop_pend_reg <= 1'b0;
          if (!stop) begin
            if (start_rec) begin
              state_reg   <= BUF_REC;
              ptr_reg     <= '0;
              length_reg  <= '0;
              overrun_reg <= 1'b0;
            end else if (start_play) begin
              if (length_reg == '0) begin
                done_reg <= 1'b1;
              end else begin
                state_reg <= BUF_PLAY;
                ptr_reg   <= '0;
              end
            end
          end
        end
        BUF_REC: begin
          if (rec_valid && port_busy) overrun_reg <= 1'b1;
          if (port_ack) ptr_reg <= ptr_next;
          if ((port_ack && ptr_next == LIMIT) || (stop_any && !in_flight)) begin
            length_reg    <= port_ack ? ptr_next : ptr_reg;
            done_reg      <= 1'b1;
            stop_pend_reg <= 1'b0;
            state_reg     <= BUF_IDLE;
          end else if (stop) begin
            stop_pend_reg <= 1'b1;
          end
        end
        BUF_PLAY: begin
          if (port_ack) ptr_reg <= ptr_next;
          if ((port_ack && ptr_next == length_reg) || (stop_any && !in_flight)) begin
            done_reg      <= 1'b1;
            stop_pend_reg <= 1'b0;
            state_reg     <= BUF_IDLE;
          end else if (stop) begin
            stop_pend_reg <= 1'b1;
          end
        end
        default: state_reg <= BUF_IDLE;
      endcase
    end
  end

  assign play_data  = port_rdata;
  assign play_valid = port_ack & (state_reg == BUF_PLAY);
  assign state_o    = state_reg;
  assign length     = length_reg;
  assign addr_o     = ptr_reg[ADDR_W-1:0];
  assign done       = done_reg;
  assign overrun    = overrun_reg;
  assign sram_ce_n  = 1'b0;
  assign sram_lb_n  = 1'b0;
  assign sram_ub_n  = 1'b0;
endmodule
